// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit single-cycle CPU: address width,
// program-counter sequencer states and the default reset vector.
package cpu_pkg;

  localparam int ADDR_W = 16;

  localparam logic [ADDR_W-1:0] DEFAULT_RESET_VECTOR = 16'h0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_t;

  // Saturating increment for the retired-instruction counter.
  function automatic logic [ADDR_W-1:0] sat_inc(input logic [ADDR_W-1:0] value);
    if (value == 16'hFFFF) begin
      sat_inc = 16'hFFFF;
    end else begin
      sat_inc = value + 16'd1;
    end
  endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: Halt > Jump > Branch > sequential,
// with the PC-relative branch adder and the region-relative jump target.
import cpu_pkg::*;

module pc_next_calc (
  input  logic [ADDR_W-1:0] pc,
  input  logic              branch_out,
  input  logic              jump,
  input  logic              halt,
  input  logic [7:0]        branch_offset,
  input  logic [11:0]       jump_target,
  output logic [ADDR_W-1:0] pc_plus2,
  output logic [ADDR_W-1:0] next_pc,
  output logic              halt_req
);

  logic [ADDR_W-1:0] offset_bytes_s;
  logic [ADDR_W-1:0] branch_pc_s;
  logic [ADDR_W-1:0] jump_pc_s;

  assign pc_plus2       = pc + 16'd2;
  // Word offset becomes a byte offset: sign-extend then shift left by one.
  assign offset_bytes_s = {{7{branch_offset[7]}}, branch_offset, 1'b0};
  assign branch_pc_s    = pc_plus2 + offset_bytes_s;
  assign jump_pc_s      = {pc_plus2[15:13], jump_target, 1'b0};

  // Priority mux for the address taken on acceptance.
  always_comb begin
    next_pc  = pc_plus2;
    halt_req = 1'b0;
    if (halt) begin
      next_pc  = pc;
      halt_req = 1'b1;
    end else if (jump) begin
      next_pc = jump_pc_s;
    end else if (branch_out) begin
      next_pc = branch_pc_s;
    end else begin
      next_pc = pc_plus2;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Registered program-counter sequencer: BOOT/RUN/HALT FSM, fetch address
// register with ready handshake, and saturating retired-instruction count.
import cpu_pkg::*;

module pc_sequencer #(
  parameter logic [ADDR_W-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Imem_Ready,
  input  logic              Branch_out,
  input  logic              Jump,
  input  logic              Halt,
  input  logic [7:0]        Branch_Offset,
  input  logic [11:0]       Jump_Target,
  output logic [ADDR_W-1:0] PC,
  output logic [ADDR_W-1:0] PC_Plus2,
  output logic              Fetch_Valid,
  output logic              Halted,
  output logic [ADDR_W-1:0] Retired_Count
);

  pc_state_t         state_r;
  logic [ADDR_W-1:0] pc_r;
  logic              fetch_valid_r;
  logic              halted_r;
  logic [ADDR_W-1:0] count_r;
  logic [ADDR_W-1:0] next_pc_s;
  logic              halt_req_s;

  pc_next_calc u_pc_next_calc (
    .pc            (pc_r),
    .branch_out    (Branch_out),
    .jump          (Jump),
    .halt          (Halt),
    .branch_offset (Branch_Offset),
    .jump_target   (Jump_Target),
    .pc_plus2      (PC_Plus2),
    .next_pc       (next_pc_s),
    .halt_req      (halt_req_s)
  );

  // FSM, PC register and retired counter; bit 0 of the PC is forced low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= BOOT;
      pc_r          <= {RESET_VECTOR[ADDR_W-1:1], 1'b0};
      fetch_valid_r <= 1'b0;
      halted_r      <= 1'b0;
      count_r       <= 16'h0000;
    end else begin
      case (state_r)
        BOOT: begin
          state_r       <= RUN;
          fetch_valid_r <= 1'b1;
          halted_r      <= 1'b0;
        end
        RUN: begin
          if (Imem_Ready) begin
            count_r <= sat_inc(count_r);
            if (halt_req_s) begin
              state_r       <= HALT;
              fetch_valid_r <= 1'b0;
              halted_r      <= 1'b1;
            end else begin
              pc_r          <= {next_pc_s[ADDR_W-1:1], 1'b0};
              fetch_valid_r <= 1'b1;
              halted_r      <= 1'b0;
            end
          end else begin
            fetch_valid_r <= 1'b1;
            halted_r      <= 1'b0;
          end
        end
        HALT: begin
          fetch_valid_r <= 1'b0;
          halted_r      <= 1'b1;
        end
        default: begin
          // Unreachable encoding: recover through the boot cycle.
          state_r       <= BOOT;
          fetch_valid_r <= 1'b0;
          halted_r      <= 1'b0;
        end
      endcase
    end
  end

  assign PC            = pc_r;
  assign Fetch_Valid   = fetch_valid_r;
  assign Halted        = halted_r;
  assign Retired_Count = count_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer: boot, branch, jump priority,
// stall, halt, reset from halt, PC wrap and counter saturation.
module tb_pc_sequencer;

  logic        clk;
  logic        rst_n, rdy, br, jmp, hlt;
  logic [7:0]  boff;
  logic [11:0] jtgt;
  logic [15:0] pc, pc2;
  logic        fv, halted;
  logic [15:0] cnt;

  logic        rst2_n, rdy2;
  logic [15:0] pc_b, pc2_b, cnt_b;
  logic        fv_b, halted_b;

  int n_checks;
  int n_fail;

  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .Imem_Ready(rdy), .Branch_out(br), .Jump(jmp),
    .Halt(hlt), .Branch_Offset(boff), .Jump_Target(jtgt), .PC(pc),
    .PC_Plus2(pc2), .Fetch_Valid(fv), .Halted(halted), .Retired_Count(cnt)
  );

  pc_sequencer #(.RESET_VECTOR(16'hFFFC)) dut_wrap (
    .clk(clk), .rst_n(rst2_n), .Imem_Ready(rdy2), .Branch_out(1'b0),
    .Jump(1'b0), .Halt(1'b0), .Branch_Offset(8'h00), .Jump_Target(12'h000),
    .PC(pc_b), .PC_Plus2(pc2_b), .Fetch_Valid(fv_b), .Halted(halted_b),
    .Retired_Count(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0; rdy = 1'b0; br = 1'b0; jmp = 1'b0; hlt = 1'b0;
    boff = 8'h00; jtgt = 12'h000;
    rst2_n = 1'b0; rdy2 = 1'b0;

    // Reset and boot
    repeat (3) step();
    chk("rst_pc", pc, 16'h0000);
    chk("rst_fv", {15'd0, fv}, 16'd0);
    chk("rst_halted", {15'd0, halted}, 16'd0);
    chk("rst_cnt", cnt, 16'h0000);
    rst_n = 1'b1; rdy = 1'b1;
    chk("boot_fv", {15'd0, fv}, 16'd0);
    step();
    chk("run_fv", {15'd0, fv}, 16'd1);
    chk("run_pc0", pc, 16'h0000);
    chk("run_pc2_plus", pc2, 16'h0002);
    step(); chk("seq_pc1", pc, 16'h0002); chk("seq_cnt1", cnt, 16'd1);
    step(); chk("seq_pc2", pc, 16'h0004); chk("seq_cnt2", cnt, 16'd2);
    step(); chk("seq_pc3", pc, 16'h0006); chk("seq_cnt3", cnt, 16'd3);
    repeat (5) step();
    chk("seq_pc10", pc, 16'h0010);

    // Branch forward then backward
    br = 1'b1; boff = 8'h03;
    step(); chk("br_fwd", pc, 16'h0018);
    boff = 8'hFC;
    step(); chk("br_back", pc, 16'h0012);
    br = 1'b0; boff = 8'h00;

    // Jump to end of region 0, walk into region 1
    jmp = 1'b1; jtgt = 12'hFFF;
    step(); chk("jmp_1ffe", pc, 16'h1FFE);
    jmp = 1'b0;
    repeat (3) step();
    chk("seq_2004", pc, 16'h2004);

    // Jump beats branch
    jmp = 1'b1; jtgt = 12'h0A5; br = 1'b1; boff = 8'h7F;
    step(); chk("jmp_prio", pc, 16'h214A); chk("jmp_cnt", cnt, 16'd15);
    br = 1'b0; boff = 8'h00; jtgt = 12'h000;

    // Stall with Jump pulsing
    rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      jmp = ~jmp;
      step();
      chk("stall_pc", pc, 16'h214A);
      chk("stall_cnt", cnt, 16'd15);
      chk("stall_fv", {15'd0, fv}, 16'd1);
    end
    jmp = 1'b0; rdy = 1'b1;
    step(); chk("unstall_pc", pc, 16'h214C); chk("unstall_cnt", cnt, 16'd16);

    // Reset mid-run, then jump to 0040 and halt there
    rst_n = 1'b0;
    step(); chk("rst2_pc", pc, 16'h0000); chk("rst2_cnt", cnt, 16'd0);
    chk("rst2_fv", {15'd0, fv}, 16'd0);
    rst_n = 1'b1;
    step();
    jmp = 1'b1; jtgt = 12'h020;
    step(); chk("jmp_0040", pc, 16'h0040); chk("jmp_0040_cnt", cnt, 16'd1);
    hlt = 1'b1;
    step();
    chk("halt_pc", pc, 16'h0040);
    chk("halt_flag", {15'd0, halted}, 16'd1);
    chk("halt_fv", {15'd0, fv}, 16'd0);
    chk("halt_cnt", cnt, 16'd2);
    hlt = 1'b0; jmp = 1'b0; br = 1'b1; boff = 8'h10;
    repeat (3) step();
    chk("halt_hold_pc", pc, 16'h0040);
    chk("halt_hold_cnt", cnt, 16'd2);
    chk("halt_hold_flag", {15'd0, halted}, 16'd1);
    br = 1'b0; boff = 8'h00;
    rst_n = 1'b0;
    step();
    chk("halt_rst_pc", pc, 16'h0000);
    chk("halt_rst_flag", {15'd0, halted}, 16'd0);
    chk("halt_rst_fv", {15'd0, fv}, 16'd0);
    chk("halt_rst_cnt", cnt, 16'd0);
    rst_n = 1'b1;

    // Wrap and saturation on the FFFC-vector instance
    rst2_n = 1'b1; rdy2 = 1'b1;
    step();
    chk("wrap_pc0", pc_b, 16'hFFFC); chk("wrap_fv", {15'd0, fv_b}, 16'd1);
    step(); chk("wrap_pc1", pc_b, 16'hFFFE); chk("wrap_plus2", pc2_b, 16'h0000);
    step(); chk("wrap_pc2", pc_b, 16'h0000); chk("wrap_cnt", cnt_b, 16'd2);
    for (int i = 0; i < 65532; i++) step();
    chk("sat_fffe", cnt_b, 16'hFFFE);
    chk("sat_pc", pc_b, 16'hFFF8);
    repeat (3) step();
    chk("sat_ffff", cnt_b, 16'hFFFF);
    chk("sat_pc2", pc_b, 16'hFFFE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
